sram_bus_arbiter: RTL and testbench
===================================

# sram_bus_arbiter

Two-to-one arbiter that shares one SRAM-like memory port between the instruction-fetch stage and the memory-access stage. It sits between the pipeline and the single memory bridge. It grants one request per cycle, holds a grant stable until the address handshake completes, and records the owner of every accepted request in an in-order tag FIFO so that each `data_ok` response reaches the requester that issued it.

## Interface
Parameters:
- `OUTSTANDING`, 2: maximum accepted-but-unanswered requests; power of two, 2..8.

Ports (`X` is `inst`, `data` or `mem`; `inst_*`/`data_*` are slave-side, `mem_*` is master-side):
- `clk`  in  1  clock; all state on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `X_req`  in (out for mem)  1  request valid.
- `X_wr`  in (out for mem)  1  1 = write.
- `X_size`  in (out for mem)  2  0/1/2 = byte/half/word.
- `X_wstrb`  in (out for mem)  4  write byte enables.
- `X_addr`  in (out for mem)  32  byte address.
- `X_wdata`  in (out for mem)  32  write data.
- `X_addr_ok`  out (in for mem)  1  address handshake.
- `X_data_ok`  out (in for mem)  1  response valid (read data or write done).
- `X_rdata`  out (in for mem)  32  read data.

## Operation
- Tag FIFO: `OUTSTANDING` entries of 1-bit owner (0 = inst, 1 = data), with pointers and a count of width clog2(`OUTSTANDING`)+1. `full` = count == `OUTSTANDING`.
- Grant FSM, two states:
  - `FREE`: no grant is locked. If not `full`, the winner among asserted `inst_req`/`data_req` is granted this cycle.
  - `LOCKED`: a request was driven to memory without `mem_addr_ok`. The locked owner stays granted regardless of the other requester, even if the FIFO becomes full.
  - `FREE`→`LOCKED` when a grant is driven and `mem_addr_ok`=0.
  - `LOCKED`→`FREE` on `mem_addr_ok`=1.
- Memory side: `mem_req` = granted requester's `req`. `mem_wr`, `size`, `wstrb`, `addr`, `wdata` are muxed from the granted requester, and are all zero when nothing is granted.
- Address acknowledge: `inst_addr_ok`/`data_addr_ok` = `mem_addr_ok` & `mem_req` & (grant == that owner). The other requester's `addr_ok` is 0.
- Push: on `mem_req & mem_addr_ok`, the owner tag is pushed.
- Pop: on `mem_data_ok`, the head tag is popped. `X_data_ok` is asserted only for the head owner. `mem_rdata` is broadcast to both `X_rdata` outputs.
- Same-cycle push and pop: count is unchanged and both pointers advance.
- `full`: a new grant is blocked in `FREE` even if a pop occurs in the same cycle (no same-cycle bypass).
- `mem_data_ok` with an empty FIFO: ignored, no `data_ok` issued, count stays 0. Simulation `$display` error under `ifndef SYNTHESIS`.
- Pointers wrap modulo `OUTSTANDING`.
- Reset (asynchronous, any time): FIFO emptied, FSM set to `FREE`, any pending `LOCKED` grant dropped. Responses still in flight are discarded: a `mem_data_ok` after reset hits the empty-FIFO case.

## Timing
- Request path is zero-latency combinational (`X_req` → `mem_req`; `mem_addr_ok` → `X_addr_ok`). Response path is also combinational (`mem_data_ok` → `X_data_ok`).
- Grant decision uses registered FSM/priority state only. There is no combinational path from `mem_data_ok` to `mem_req`.
- Outputs during reset and after reset (no requests): every `mem_*` output 0, every `X_addr_ok`/`X_data_ok` 0, `X_rdata` = `mem_rdata`.
- Back-to-back: one accepted request per cycle when `mem_addr_ok` is held high and the FIFO is not full.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin priority. A 1-bit `last_owner` register, reset to 1 (inst wins first), is updated on each push. On contention, the owner that did not win last is granted.
- Undefined: fixed priority, data over inst (memory-stage requests never starve behind fetch). No `last_owner` register.

## Test plan
- Single inst read: `inst_req`=1, `inst_addr`=0x1c000000, `mem_addr_ok`=1 → `mem_addr`=0x1c000000, `inst_addr_ok`=1. `mem_data_ok` with 0x02800000 two cycles later → `inst_data_ok`=1, `inst_rdata`=0x02800000, `data_data_ok`=0.
- Contention: both `req`=1 every cycle, `mem_addr_ok`=1 → fixed mode: data granted each cycle and inst starved. With `ARB_ROUND_ROBIN_EN`: inst, data, inst, data…
- Lock: `inst_req`=1 with `mem_addr_ok`=0 for 3 cycles, `data_req` raised in cycle 2 → `mem_addr` stays on the inst address. First `addr_ok` goes to inst; data is granted next.
- Full: `OUTSTANDING`=2, two requests accepted with no `data_ok` → third request sees `mem_req`=0. One `mem_data_ok` → third request accepted the following cycle.
- Ordering: accept inst, data, inst, then 3 `mem_data_ok` pulses → `data_ok` routed inst, data, inst. Also push and pop in the same cycle with count 1 → count stays 1.
- Reset mid-flight: 2 outstanding, `resetn` pulsed low → all outputs 0 immediately. A later `mem_data_ok` produces no `X_data_ok`.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like port between fetch (inst) and memory (data) stages.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin priority; otherwise data has fixed priority over inst.
module sram_bus_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state_r, state_nxt_s;
    logic               lock_owner_r, lock_owner_nxt_s;
    logic               grant_vld_s, grant_owner_s;
    logic               prefer_data_s;
    logic [OUTSTANDING-1:0] tag_r;
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               full_s, empty_s, push_s, pop_s, head_owner_s;

    assign full_s  = (count_r == FULL_CNT);
    assign empty_s = (count_r == {CNT_W{1'b0}});

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_r;

    // Winner of the most recent accepted request; inst wins the first contention.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_owner_r <= 1'b1;
        end else if (push_s) begin
            last_owner_r <= grant_owner_s;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end

    assign prefer_data_s = ~last_owner_r;
`else
    assign prefer_data_s = 1'b1;
`endif

    // Grant selection from registered state; a locked owner keeps the port even when full.
    always_comb begin
        grant_vld_s   = 1'b0;
        grant_owner_s = OWNER_INST;
        case (state_r)
            LOCKED: begin
                grant_vld_s   = 1'b1;
                grant_owner_s = lock_owner_r;
            end
            FREE: begin
                if (!full_s && (inst_req || data_req)) begin
                    grant_vld_s = 1'b1;
                    if (inst_req && data_req) begin
                        grant_owner_s = prefer_data_s;
                    end else begin
                        grant_owner_s = data_req;
                    end
                end else begin
                    grant_vld_s = 1'b0;
                end
            end
            default: begin
                grant_vld_s   = 1'b0;
                grant_owner_s = OWNER_INST;
            end
        endcase
    end

    // Memory-side request mux; all fields read as zero while nothing is granted.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (grant_vld_s && (grant_owner_s == OWNER_DATA)) begin
            mem_req   = data_req;
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (grant_vld_s) begin
            mem_req   = inst_req;
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_wstrb = inst_wstrb;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end else begin
            mem_req   = 1'b0;
        end
    end

    // Lock bookkeeping: hold the grant until the address handshake completes.
    always_comb begin
        state_nxt_s      = state_r;
        lock_owner_nxt_s = lock_owner_r;
        case (state_r)
            FREE: begin
                if (mem_req && !mem_addr_ok) begin
                    state_nxt_s      = LOCKED;
                    lock_owner_nxt_s = grant_owner_s;
                end else begin
                    state_nxt_s      = FREE;
                end
            end
            LOCKED: begin
                if (mem_addr_ok) begin
                    state_nxt_s = FREE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = FREE;
            end
        endcase
    end

    // Grant FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= FREE;
            lock_owner_r <= OWNER_INST;
        end else begin
            state_r      <= state_nxt_s;
            lock_owner_r <= lock_owner_nxt_s;
        end
    end

    assign push_s       = mem_req & mem_addr_ok;
    assign pop_s        = mem_data_ok & ~empty_s;
    assign head_owner_s = tag_r[rd_ptr_r];

    assign inst_addr_ok = push_s & (grant_owner_s == OWNER_INST);
    assign data_addr_ok = push_s & (grant_owner_s == OWNER_DATA);
    assign inst_data_ok = pop_s & (head_owner_s == OWNER_INST);
    assign data_data_ok = pop_s & (head_owner_s == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // In-order owner tag FIFO; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_r    <= {OUTSTANDING{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tag_r[wr_ptr_r] <= grant_owner_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding is dropped; report it in simulation.
    always @(posedge clk) begin
        if (resetn && mem_data_ok && empty_s) begin
            $display("sram_bus_arbiter: stray mem_data_ok with empty tag FIFO at %0t, response dropped", $time);
        end
    end
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: expected handshakes are queued by the stimulus
// and consumed by a negedge monitor whenever the DUT asserts addr_ok or data_ok.
module tb_sram_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct packed {
        logic        owner;
        logic [31:0] val;
    } exp_t;

    exp_t addr_q[$];
    exp_t data_q[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_last;

    localparam logic [31:0] ADDR_A  = 32'h0000_1000;
    localparam logic [31:0] ADDR_B  = 32'h8000_2000;
    localparam logic [31:0] RD_BASE = 32'h1000_0000;

    sram_bus_arbiter #(.OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_addr(input logic owner, input logic [31:0] a);
        addr_q.push_back(exp_t'{owner: owner, val: a});
        exp_last = owner;
    endtask

    task automatic exp_data(input logic owner, input logic [31:0] d);
        data_q.push_back(exp_t'{owner: owner, val: d});
    endtask

    task automatic idle();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'd0;
        inst_addr = 32'd0; inst_wdata = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'd0;
        data_addr = 32'd0; data_wdata = 32'd0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    endtask

    // Monitor: consume one expectation per observed handshake.
    always @(negedge clk) begin : mon_blk
        exp_t e;
        if (inst_addr_ok || data_addr_ok) begin
            checks++;
            if (addr_q.size() == 0) begin
                errors++;
                $display("FAIL addr_ok: got handshake inst=%0b data=%0b addr=%h expected none",
                         inst_addr_ok, data_addr_ok, mem_addr);
            end else begin
                e = addr_q.pop_front();
                if ((inst_addr_ok && data_addr_ok) || (data_addr_ok != e.owner) || (mem_addr !== e.val)) begin
                    errors++;
                    $display("FAIL addr_ok: got inst=%0b data=%0b addr=%h expected owner=%0b addr=%h",
                             inst_addr_ok, data_addr_ok, mem_addr, e.owner, e.val);
                end
            end
        end
        if (inst_data_ok || data_data_ok) begin
            checks++;
            if (data_q.size() == 0) begin
                errors++;
                $display("FAIL data_ok: got response inst=%0b data=%0b expected none",
                         inst_data_ok, data_data_ok);
            end else begin
                e = data_q.pop_front();
                if ((inst_data_ok && data_data_ok) || (data_data_ok != e.owner) ||
                    (inst_rdata !== e.val) || (data_rdata !== e.val)) begin
                    errors++;
                    $display("FAIL data_ok: got inst=%0b data=%0b rdata=%h/%h expected owner=%0b rdata=%h",
                             inst_data_ok, data_data_ok, inst_rdata, data_rdata, e.owner, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic owner;
        idle();
        exp_last  = 1'b1;
        resetn    = 1'b0;
        mem_rdata = 32'hdead_beef;
        #12;
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset inst_rdata", inst_rdata, 32'hdead_beef);
        resetn = 1'b1;
        tick();
        check("idle mem_req", 32'(mem_req), 32'd0);
        check("idle addr_ok", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);

        // Single inst read, response two cycles later.
        exp_addr(1'b0, 32'h1c00_0000);
        exp_data(1'b0, 32'h0280_0000);
        inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
        tick();
        idle();
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h0280_0000;
        tick();
        idle();
        tick();

        // Contention with pipelined responses (push and pop in the same cycle).
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            owner = ~exp_last;
`else
            owner = 1'b1;
`endif
            exp_addr(owner, owner ? ADDR_B : ADDR_A);
            exp_data(owner, RD_BASE + 32'(i));
            inst_req = 1'b1; inst_addr = ADDR_A;
            data_req = 1'b1; data_addr = ADDR_B;
            mem_addr_ok = 1'b1;
            mem_data_ok = (i > 0);
            mem_rdata   = RD_BASE + 32'(i) - 32'd1;
            tick();
        end
        idle();
        mem_data_ok = 1'b1; mem_rdata = RD_BASE + 32'd3;
        tick();
        idle();
        tick();

        // Lock: inst held without addr_ok while data also requests.
        inst_req = 1'b1; inst_addr = 32'h0000_00c0;
        #1 check("lock c1 mem_addr", mem_addr, 32'h0000_00c0);
        tick();
        data_req = 1'b1; data_addr = 32'h0000_00d0;
        data_wr = 1'b1; data_wstrb = 4'hf; data_wdata = 32'hcafe_f00d;
        #1 check("lock c2 mem_addr", mem_addr, 32'h0000_00c0);
        tick();
        #1 check("lock c3 mem_addr", mem_addr, 32'h0000_00c0);
        check("lock c3 mem_wr", 32'(mem_wr), 32'd0);
        tick();
        exp_addr(1'b0, 32'h0000_00c0);
        exp_data(1'b0, 32'h0000_c0c0);
        mem_addr_ok = 1'b1;
        tick();
        exp_addr(1'b1, 32'h0000_00d0);
        exp_data(1'b1, 32'h0000_d0d0);
        inst_req = 1'b0;
        #1 check("write mem_wr", 32'(mem_wr), 32'd1);
        check("write mem_wdata", mem_wdata, 32'hcafe_f00d);
        check("write mem_wstrb", 32'(mem_wstrb), 32'hf);
        tick();

        // Full: a pop in the same cycle must not let a new grant through.
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'd0; data_wdata = 32'd0;
        inst_req = 1'b1; inst_addr = 32'h0000_00e0;
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_c0c0;
        #1 check("full mem_req", 32'(mem_req), 32'd0);
        tick();
        mem_data_ok = 1'b0;
        exp_addr(1'b0, 32'h0000_00e0);
        exp_data(1'b0, 32'h0000_e0e0);
        #1 check("after pop mem_req", 32'(mem_req), 32'd1);
        tick();
        idle();
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_d0d0;
        tick();
        mem_rdata = 32'h0000_e0e0;
        tick();
        idle();
        tick();

        // Ordering inst, data, inst with a push+pop at count 1.
        exp_addr(1'b0, 32'h0000_0f00);
        exp_data(1'b0, 32'h0000_0001);
        inst_req = 1'b1; inst_addr = 32'h0000_0f00; mem_addr_ok = 1'b1;
        tick();
        exp_addr(1'b1, 32'h0000_0a00);
        exp_data(1'b1, 32'h0000_0002);
        inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0a00;
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_0001;
        tick();
        check("push+pop count", 32'(dut.count_r), 32'd1);
        exp_addr(1'b0, 32'h0000_0b00);
        exp_data(1'b0, 32'h0000_0003);
        data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h0000_0b00; mem_data_ok = 1'b0;
        tick();
        check("count two", 32'(dut.count_r), 32'd2);
        idle();
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_0002;
        tick();
        mem_rdata = 32'h0000_0003;
        tick();
        idle();
        tick();

        // Reset with two requests in flight; late responses are dropped.
        exp_addr(1'b0, 32'h0000_0100);
        inst_req = 1'b1; inst_addr = 32'h0000_0100; mem_addr_ok = 1'b1;
        tick();
        exp_addr(1'b1, 32'h0000_0200);
        inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0200;
        tick();
        idle();
        #1 resetn = 1'b0;
        exp_last = 1'b1;
        #1 check("midreset mem_req", 32'(mem_req), 32'd0);
        check("midreset mem_addr", mem_addr, 32'd0);
        check("midreset count", 32'(dut.count_r), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h5555_aaaa;
        #1 check("stale data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        tick();
        idle();
        tick();

        check("addr_q drained", 32'(addr_q.size()), 32'd0);
        check("data_q drained", 32'(data_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
